// File: rtl/mux_nway_pipe.sv
// mux_nway_pipe: N-channel, W-bit selector feeding a registered valid/ready output stage.
// A held select register picks the channel. Only the selected channel sees in_ready, and only
// when the output register is empty or is being drained this cycle.
// Optional build macro MUX_RR_SCAN_EN adds an rr_mode input. With rr_mode set, the select
// register hops to the next valid channel after every transfer.
// The default build (macro undefined) has no rr_mode port.

module mux_nway_pipe #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
`ifdef MUX_RR_SCAN_EN
    input  logic                      rr_mode,
`endif
    output logic [SEL_W-1:0]          sel_cur,
    output logic                      sel_err,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    r_sel;
    logic                r_sel_err;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;

    logic                w_can_accept;
    logic                w_sel_ok;
    logic                w_sel_valid;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_xfer;
    logic [CHANNELS-1:0] w_in_ready;

    // The output register can take a new beat when empty or when it is being drained.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_sel_ok     = (32'(sel) < CHANNELS);

    // Pick the selected channel's valid/data and build the one-hot ready vector.
    // Loops with compares avoid out-of-range bit selects when CHANNELS is not a power of two.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_in_ready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == r_sel) begin
                w_sel_valid   = in_valid[i];
                w_sel_data    = in_data[i*WIDTH +: WIDTH];
                // Held at zero during reset so no producer sees an accept it cannot rely on.
                w_in_ready[i] = w_can_accept && !rst;
            end
        end
    end

    assign w_xfer = w_sel_valid && w_can_accept;

`ifdef MUX_RR_SCAN_EN
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_next;
    int unsigned      w_rr_idx;

    // Find the first valid channel strictly after r_sel, wrapping at CHANNELS-1.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_next  = r_sel;
        w_rr_idx   = 0;
        for (int unsigned k = 1; k < CHANNELS; k++) begin
            w_rr_idx = 32'(r_sel) + k;
            if (w_rr_idx >= CHANNELS) begin
                w_rr_idx = w_rr_idx - CHANNELS;
            end
            if (!w_rr_found && in_valid[w_rr_idx[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_next  = w_rr_idx[SEL_W-1:0];
            end
        end
    end
`endif

    // Select register: accepted loads win; rejected loads raise a one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= sel_load && !w_sel_ok;
            if (sel_load && w_sel_ok) begin
                r_sel <= sel;
`ifdef MUX_RR_SCAN_EN
            end else if (rr_mode && w_xfer && w_rr_found) begin
                r_sel <= w_rr_next;
`endif
            end
        end
    end

    // Output stage: load on transfer (replacing any beat being drained), else drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= r_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign sel_cur   = r_sel;
    assign sel_err   = r_sel_err;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
